// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding RV32I memory access, byte/half/word extraction.
// Optional misaligned-access rejection is enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_is_load_i,
   input  logic                  req_is_store_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [DATA_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  resp_valid_o,
   output logic [DATA_WIDTH-1:0] resp_rdata_o,
   output logic                  misalign_o,
   output logic                  mem_read_en_o,
   output logic                  mem_write_en_o,
   output logic [2:0]            mem_funct3_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

   state_t                  state_reg, state_next;
   logic                    is_load_reg, is_store_reg;
   logic [2:0]              funct3_reg;
   logic [DATA_WIDTH-1:0]   addr_reg, wdata_reg;
   logic [DATA_WIDTH-1:0]   rdata_reg, rdata_next;
   logic                    accept;
   logic                    legal_load, legal_store;
   logic                    misaligned;
   logic [DATA_WIDTH-1:0]   extracted;
   logic [7:0]              byte_lane [4];
   logic [15:0]             half_lane [2];

   assign accept = (state_reg == IDLE) && req_valid_i;

   assign legal_load  = is_load_reg && !is_store_reg &&
                        (funct3_reg inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
   assign legal_store = is_store_reg && !is_load_reg && (funct3_reg <= 3'b010);

`ifdef LSU_MISALIGN_TRAP_EN
   logic align_fault;

   always_comb begin
      align_fault = 1'b0;
      case (funct3_reg[1:0])
         2'b01:   align_fault = addr_reg[0];
         2'b10:   align_fault = |addr_reg[1:0];
         default: align_fault = 1'b0;
      endcase
   end

   // Only a legal access can be misaligned; illegal ones complete without the flag.
   assign misaligned = (legal_load || legal_store) && align_fault;
   assign misalign_o = (state_reg == RESP) && misaligned;
`else
   assign misaligned = 1'b0;
   assign misalign_o = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_byte_lane
         assign byte_lane[gi] = mem_rdata_i[8*gi +: 8];
      end
      for (gi = 0; gi < 2; gi++) begin : g_half_lane
         assign half_lane[gi] = mem_rdata_i[16*gi +: 16];
      end
   endgenerate

   always_comb begin
      extracted = mem_rdata_i;
      case (funct3_reg)
         3'b000:  extracted = {{(DATA_WIDTH-8){byte_lane[addr_reg[1:0]][7]}}, byte_lane[addr_reg[1:0]]};
         3'b100:  extracted = {{(DATA_WIDTH-8){1'b0}}, byte_lane[addr_reg[1:0]]};
         3'b001:  extracted = {{(DATA_WIDTH-16){half_lane[addr_reg[1]][15]}}, half_lane[addr_reg[1]]};
         3'b101:  extracted = {{(DATA_WIDTH-16){1'b0}}, half_lane[addr_reg[1]]};
         default: extracted = mem_rdata_i;
      endcase
   end

   always_comb begin
      state_next = state_reg;
      rdata_next = rdata_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid_i) begin
               state_next = ISSUE;
               rdata_next = '0;
            end
         end
         ISSUE: begin
            if (legal_load && !misaligned) state_next = CAPTURE;
            else                           state_next = RESP;
         end
         CAPTURE: begin
            state_next = RESP;
            rdata_next = extracted;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         is_load_reg  <= 1'b0;
         is_store_reg <= 1'b0;
         funct3_reg   <= 3'b000;
         addr_reg     <= '0;
         wdata_reg    <= '0;
         rdata_reg    <= '0;
      end else begin
         state_reg <= state_next;
         rdata_reg <= rdata_next;
         if (accept) begin
            is_load_reg  <= req_is_load_i;
            is_store_reg <= req_is_store_i;
            funct3_reg   <= req_funct3_i;
            addr_reg     <= req_addr_i;
            wdata_reg    <= req_wdata_i;
         end
      end
   end

   // Ready is gated by rst_n so every output reads 0 while reset is held.
   assign req_ready_o    = (state_reg == IDLE) && rst_n;
   assign resp_valid_o   = (state_reg == RESP);
   assign resp_rdata_o   = rdata_reg;
   assign mem_read_en_o  = (state_reg == ISSUE) && legal_load && !misaligned;
   assign mem_write_en_o = (state_reg == ISSUE) && legal_store && !misaligned;
   assign mem_funct3_o   = funct3_reg;
   assign mem_addr_o     = addr_reg;
   assign mem_wdata_o    = wdata_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit with a small word-addressed data memory model.
// Expectations adapt to LSU_MISALIGN_TRAP_EN when that macro is defined.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_is_load = 1'b0;
   logic        req_is_store = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        misalign;
   logic        mem_read_en, mem_write_en;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_addr, mem_wdata;
   logic [31:0] mem_rdata = '0;

   int pass_cnt = 0;
   int total_cnt = 0;

   // Observations from the most recent transaction.
   int          obs_rd, obs_wr, obs_both, obs_first, obs_resp_n, obs_ready_busy;
   logic        obs_accept_ready, obs_mis;
   logic [31:0] obs_rdata, obs_maddr, obs_mwdata;

   logic [31:0] mem [64];

   always #5 clk = ~clk;

   load_store_unit #(.DATA_WIDTH(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid_i    (req_valid),
      .req_ready_o    (req_ready),
      .req_is_load_i  (req_is_load),
      .req_is_store_i (req_is_store),
      .req_funct3_i   (req_funct3),
      .req_addr_i     (req_addr),
      .req_wdata_i    (req_wdata),
      .resp_valid_o   (resp_valid),
      .resp_rdata_o   (resp_rdata),
      .misalign_o     (misalign),
      .mem_read_en_o  (mem_read_en),
      .mem_write_en_o (mem_write_en),
      .mem_funct3_o   (mem_funct3),
      .mem_addr_o     (mem_addr),
      .mem_wdata_o    (mem_wdata),
      .mem_rdata_i    (mem_rdata)
   );

   // Data memory: registered read, byte/half/word writes on the addressed lanes.
   always @(posedge clk) begin
      if (mem_read_en) mem_rdata <= mem[mem_addr[7:2]];
      if (mem_write_en) begin
         case (mem_funct3[1:0])
            2'b00:   mem[mem_addr[7:2]][{mem_addr[1:0], 3'b000} +: 8] <= mem_wdata[7:0];
            2'b01:   mem[mem_addr[7:2]][{mem_addr[1], 4'b0000} +: 16] <= mem_wdata[15:0];
            default: mem[mem_addr[7:2]] <= mem_wdata;
         endcase
      end
   end

   task automatic do_req(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd);
      @(negedge clk);
      req_valid = 1'b1; req_is_load = ld; req_is_store = st;
      req_funct3 = f3; req_addr = a; req_wdata = wd;
      obs_accept_ready = req_ready;
      obs_rd = 0; obs_wr = 0; obs_both = 0; obs_first = 0; obs_resp_n = 0; obs_ready_busy = 0;
      obs_mis = 1'b0; obs_rdata = 'x; obs_maddr = 'x; obs_mwdata = 'x;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         if (mem_read_en && mem_write_en) obs_both++;
         if ((mem_read_en || mem_write_en) && obs_first == 0) begin
            obs_first = n; obs_maddr = mem_addr; obs_mwdata = mem_wdata;
         end
         if (mem_read_en) obs_rd++;
         if (mem_write_en) obs_wr++;
         if (req_ready) obs_ready_busy++;
         if (resp_valid) begin
            obs_resp_n = n; obs_rdata = resp_rdata; obs_mis = misalign;
            break;
         end
      end
      $display("txn ld=%0b st=%0b f3=%03b addr=%08h wdata=%08h -> rd=%0d wr=%0d resp@%0d rdata=%08h mis=%0b",
               ld, st, f3, a, wd, obs_rd, obs_wr, obs_resp_n, obs_rdata, obs_mis);
   endtask

   task automatic test_reset();
      #12;
      total_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready got=%0b want=0", req_ready); else pass_cnt++;
      total_cnt++; if ({resp_valid, misalign, mem_read_en, mem_write_en} !== 4'b0)
         $display("FAIL rst_flags got=%04b want=0000", {resp_valid, misalign, mem_read_en, mem_write_en}); else pass_cnt++;
      total_cnt++; if ({mem_addr, mem_wdata, resp_rdata} !== 96'd0)
         $display("FAIL rst_data got=%08h/%08h/%08h want=0", mem_addr, mem_wdata, resp_rdata); else pass_cnt++;
      total_cnt++; if (mem_funct3 !== 3'b000) $display("FAIL rst_funct3 got=%03b want=000", mem_funct3); else pass_cnt++;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL rst_release_ready got=%0b want=1", req_ready); else pass_cnt++;
   endtask

   task automatic test_store_load();
      do_req(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
      total_cnt++; if (obs_accept_ready !== 1'b1) $display("FAIL sw_ready got=%0b want=1", obs_accept_ready); else pass_cnt++;
      total_cnt++; if (obs_wr !== 1 || obs_rd !== 0) $display("FAIL sw_strobes got wr=%0d rd=%0d want wr=1 rd=0", obs_wr, obs_rd); else pass_cnt++;
      total_cnt++; if (obs_first !== 1) $display("FAIL sw_strobe_time got=%0d want=1", obs_first); else pass_cnt++;
      total_cnt++; if (obs_maddr !== 32'h10 || obs_mwdata !== 32'hDEADBEEF)
         $display("FAIL sw_mem_bus got=%08h/%08h want=00000010/deadbeef", obs_maddr, obs_mwdata); else pass_cnt++;
      total_cnt++; if (obs_resp_n !== 2) $display("FAIL sw_latency got=%0d want=2", obs_resp_n); else pass_cnt++;
      total_cnt++; if (obs_rdata !== 32'h0) $display("FAIL sw_rdata got=%08h want=00000000", obs_rdata); else pass_cnt++;
      total_cnt++; if (obs_ready_busy !== 0) $display("FAIL sw_ready_busy got=%0d want=0", obs_ready_busy); else pass_cnt++;
      do_req(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      total_cnt++; if (obs_rd !== 1 || obs_wr !== 0) $display("FAIL lw_strobes got rd=%0d wr=%0d want rd=1 wr=0", obs_rd, obs_wr); else pass_cnt++;
      total_cnt++; if (obs_resp_n !== 3) $display("FAIL lw_latency got=%0d want=3", obs_resp_n); else pass_cnt++;
      total_cnt++; if (obs_rdata !== 32'hDEADBEEF) $display("FAIL lw_rdata got=%08h want=deadbeef", obs_rdata); else pass_cnt++;
      total_cnt++; if (obs_both !== 0) $display("FAIL lw_both_strobes got=%0d want=0", obs_both); else pass_cnt++;
   endtask

   task automatic test_extract();
      do_req(1'b0, 1'b1, 3'b010, 32'h20, 32'h80F17F01);
      do_req(1'b1, 1'b0, 3'b000, 32'h23, 32'h0);
      total_cnt++; if (obs_rdata !== 32'hFFFFFF80) $display("FAIL lb got=%08h want=ffffff80", obs_rdata); else pass_cnt++;
      do_req(1'b1, 1'b0, 3'b100, 32'h23, 32'h0);
      total_cnt++; if (obs_rdata !== 32'h00000080) $display("FAIL lbu got=%08h want=00000080", obs_rdata); else pass_cnt++;
      do_req(1'b1, 1'b0, 3'b001, 32'h22, 32'h0);
      total_cnt++; if (obs_rdata !== 32'hFFFF80F1) $display("FAIL lh got=%08h want=ffff80f1", obs_rdata); else pass_cnt++;
      do_req(1'b1, 1'b0, 3'b101, 32'h20, 32'h0);
      total_cnt++; if (obs_rdata !== 32'h00007F01) $display("FAIL lhu got=%08h want=00007f01", obs_rdata); else pass_cnt++;
      // Sub-word stores must only touch their own lanes.
      do_req(1'b0, 1'b1, 3'b010, 32'h30, 32'h11223344);
      do_req(1'b0, 1'b1, 3'b001, 32'h32, 32'h7777ABCD);
      do_req(1'b0, 1'b1, 3'b000, 32'h31, 32'h66666655);
      do_req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
      total_cnt++; if (obs_rdata !== 32'hABCD5544) $display("FAIL sh_sb_lanes got=%08h want=abcd5544", obs_rdata); else pass_cnt++;
   endtask

   task automatic test_misalign();
      do_req(1'b1, 1'b0, 3'b010, 32'h21, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      total_cnt++; if (obs_rd + obs_wr !== 0) $display("FAIL lw_mis_strobe got=%0d want=0", obs_rd + obs_wr); else pass_cnt++;
      total_cnt++; if (obs_resp_n !== 2 || obs_mis !== 1'b1)
         $display("FAIL lw_mis_resp got resp@%0d mis=%0b want resp@2 mis=1", obs_resp_n, obs_mis); else pass_cnt++;
      total_cnt++; if (obs_rdata !== 32'h0) $display("FAIL lw_mis_rdata got=%08h want=00000000", obs_rdata); else pass_cnt++;
`else
      total_cnt++; if (obs_rd !== 1) $display("FAIL lw_mis_strobe got=%0d want=1", obs_rd); else pass_cnt++;
      total_cnt++; if (obs_resp_n !== 3 || obs_mis !== 1'b0)
         $display("FAIL lw_mis_resp got resp@%0d mis=%0b want resp@3 mis=0", obs_resp_n, obs_mis); else pass_cnt++;
      total_cnt++; if (obs_rdata !== 32'h80F17F01) $display("FAIL lw_mis_rdata got=%08h want=80f17f01", obs_rdata); else pass_cnt++;
`endif
      do_req(1'b1, 1'b0, 3'b001, 32'h23, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
      total_cnt++; if (obs_rd !== 0 || obs_resp_n !== 2 || obs_mis !== 1'b1 || obs_rdata !== 32'h0)
         $display("FAIL lh_mis got rd=%0d resp@%0d mis=%0b rdata=%08h want 0/2/1/0", obs_rd, obs_resp_n, obs_mis, obs_rdata); else pass_cnt++;
`else
      total_cnt++; if (obs_rd !== 1 || obs_resp_n !== 3 || obs_mis !== 1'b0 || obs_rdata !== 32'hFFFF80F1)
         $display("FAIL lh_mis got rd=%0d resp@%0d mis=%0b rdata=%08h want 1/3/0/ffff80f1", obs_rd, obs_resp_n, obs_mis, obs_rdata); else pass_cnt++;
`endif
   endtask

   task automatic test_illegal();
      logic [4:0] vec [4];
      vec[0] = {2'b10, 3'b011};  // load, funct3 011
      vec[1] = {2'b11, 3'b010};  // both flags
      vec[2] = {2'b00, 3'b000};  // neither flag
      vec[3] = {2'b01, 3'b011};  // store, funct3 011
      for (int i = 0; i < 4; i++) begin
         do_req(vec[i][4], vec[i][3], vec[i][2:0], 32'h21, 32'h12345678);
         total_cnt++; if (obs_rd + obs_wr !== 0) $display("FAIL illegal%0d_strobe got=%0d want=0", i, obs_rd + obs_wr); else pass_cnt++;
         total_cnt++; if (obs_resp_n !== 2 || obs_mis !== 1'b0 || obs_rdata !== 32'h0)
            $display("FAIL illegal%0d_resp got resp@%0d mis=%0b rdata=%08h want 2/0/0", i, obs_resp_n, obs_mis, obs_rdata); else pass_cnt++;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrs [4];
      logic [2:0]  f3s [4];
      logic [31:0] expv [4];
      int acc_cyc [4];
      int acc = 0, rsp = 0, rd_cnt = 0;
      logic just_acc = 1'b0;
      addrs[0] = 32'h20; f3s[0] = 3'b010; expv[0] = 32'h80F17F01;
      addrs[1] = 32'h23; f3s[1] = 3'b000; expv[1] = 32'hFFFFFF80;
      addrs[2] = 32'h32; f3s[2] = 3'b101; expv[2] = 32'h0000ABCD;
      addrs[3] = 32'h10; f3s[3] = 3'b010; expv[3] = 32'hDEADBEEF;
      @(negedge clk);
      req_valid = 1'b1; req_is_load = 1'b1; req_is_store = 1'b0;
      req_funct3 = f3s[0]; req_addr = addrs[0];
      for (int cyc = 0; cyc < 24; cyc++) begin
         if (just_acc) begin
            if (acc < 4) begin req_funct3 = f3s[acc]; req_addr = addrs[acc]; end
            else req_valid = 1'b0;
            just_acc = 1'b0;
         end
         if (mem_read_en) rd_cnt++;
         if (resp_valid) begin
            $display("b2b resp %0d cyc=%0d rdata=%08h", rsp, cyc, resp_rdata);
            if (rsp < 4) begin
               total_cnt++; if (resp_rdata !== expv[rsp])
                  $display("FAIL b2b_rdata%0d got=%08h want=%08h", rsp, resp_rdata, expv[rsp]); else pass_cnt++;
            end
            rsp++;
         end
         if (req_ready && req_valid) begin
            if (acc < 4) acc_cyc[acc] = cyc;
            acc++; just_acc = 1'b1;
         end
         @(negedge clk);
      end
      req_valid = 1'b0;
      total_cnt++; if (acc !== 4) $display("FAIL b2b_accepts got=%0d want=4", acc); else pass_cnt++;
      total_cnt++; if (rsp !== 4) $display("FAIL b2b_resps got=%0d want=4", rsp); else pass_cnt++;
      total_cnt++; if (rd_cnt !== 4) $display("FAIL b2b_reads got=%0d want=4", rd_cnt); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         if (i + 1 < acc) begin
            total_cnt++; if (acc_cyc[i+1] - acc_cyc[i] !== 4)
               $display("FAIL b2b_spacing%0d got=%0d want=4", i, acc_cyc[i+1] - acc_cyc[i]); else pass_cnt++;
         end
      end
   endtask

   task automatic test_reset_mid();
      int stray = 0;
      @(negedge clk);
      req_valid = 1'b1; req_is_load = 1'b0; req_is_store = 1'b1;
      req_funct3 = 3'b000; req_addr = 32'h30; req_wdata = 32'h00000099;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      total_cnt++; if (mem_write_en !== 1'b1) $display("FAIL rmid_issue_wr got=%0b want=1", mem_write_en); else pass_cnt++;
      #1 rst_n = 1'b0;
      #1;
      total_cnt++; if (mem_write_en !== 1'b0) $display("FAIL rmid_wr_drop got=%0b want=0", mem_write_en); else pass_cnt++;
      total_cnt++; if (mem_addr !== 32'h0) $display("FAIL rmid_addr_clear got=%08h want=00000000", mem_addr); else pass_cnt++;
      @(negedge clk);
      #2 rst_n = 1'b1;
      @(posedge clk);
      #1;
      total_cnt++; if (req_ready !== 1'b1) $display("FAIL rmid_ready got=%0b want=1", req_ready); else pass_cnt++;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         if (resp_valid) stray++;
      end
      total_cnt++; if (stray !== 0) $display("FAIL rmid_no_resp got=%0d want=0", stray); else pass_cnt++;
      do_req(1'b1, 1'b0, 3'b010, 32'h30, 32'h0);
      total_cnt++; if (obs_rdata !== 32'hABCD5544) $display("FAIL rmid_mem_untouched got=%08h want=abcd5544", obs_rdata); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_extract();
      test_misalign();
      test_illegal();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
